// File: rtl/frac_n_pkg.sv
// frac_n_pkg: shared state type and constants for the fractional-N feedback divider
package frac_n_pkg;
  typedef enum logic {IDLE, COUNT} state_t;
  localparam int DN_BITS = 4;
  localparam int MIN_DIV_DEF = 4;
endpackage

// File: rtl/frac_n_divider_if.sv
// frac_n_divider_if: modulator-side bundle (enable, n_int, dn in; div_pulse, div_clk, dn_take, clamped out)
interface frac_n_divider_if
  import frac_n_pkg::*;
#(
  parameter int NBITS = 8
);
  logic enable;
  logic [NBITS-1:0] n_int;
  logic [DN_BITS-1:0] dn;
  logic div_pulse;
  logic div_clk;
  logic dn_take;
  logic clamped;
  modport master (output enable, n_int, dn, input div_pulse, div_clk, dn_take, clamped);
  modport slave (input enable, n_int, dn, output div_pulse, div_clk, dn_take, clamped);
endinterface

// File: rtl/frac_n_divider_div_modulus.sv
// div_modulus: m = n_int + signed dn, clamped up to MIN_DIV (clamp_hit flags it); ports n_int, dn in; m, clamp_hit out
module div_modulus
  import frac_n_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int MIN_DIV = MIN_DIV_DEF
) (
  input  logic [NBITS-1:0]   n_int,
  input  logic [DN_BITS-1:0] dn,
  output logic [NBITS:0]     m,
  output logic               clamp_hit
);
  localparam logic signed [NBITS+1:0] MIN_S = (NBITS+2)'(MIN_DIV);
  logic signed [NBITS+1:0] sum;
  assign sum = $signed({2'b00, n_int}) + $signed({{(NBITS+2-DN_BITS){dn[DN_BITS-1]}}, dn});
  assign clamp_hit = sum < MIN_S;
  assign m = clamp_hit ? (NBITS+1)'(MIN_DIV) : sum[NBITS:0];
endmodule

// File: rtl/frac_n_divider.sv
// frac_n_divider: N+dn multi-modulus divider; ports clk, rst_n, bus (enable, n_int, dn in; div_pulse, div_clk, dn_take, clamped out)
module frac_n_divider
  import frac_n_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int MIN_DIV = MIN_DIV_DEF
) (
  input logic clk,
  input logic rst_n,
  frac_n_divider_if.slave bus
);
  state_t state;
  logic [NBITS:0] cnt, half, m, cnt_dec;
  logic hit, pulse, dclk, take, clmp;
  assign cnt_dec = cnt - (NBITS+1)'(1);
  div_modulus #(.NBITS(NBITS), .MIN_DIV(MIN_DIV)) u_mod (
    .n_int(bus.n_int),
    .dn(bus.dn),
    .m(m),
    .clamp_hit(hit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      half <= '0;
      pulse <= 1'b0;
      dclk <= 1'b0;
      take <= 1'b0;
      clmp <= 1'b0;
    end else if (!bus.enable) begin
      state <= IDLE;
      cnt <= '0;
      half <= '0;
      pulse <= 1'b0;
      dclk <= 1'b0;
      take <= 1'b0;
      clmp <= 1'b0;
    end else if (state == IDLE || cnt == '0) begin
      state <= COUNT;
      cnt <= m - (NBITS+1)'(1);
      half <= m >> 1;
      pulse <= state == COUNT;
      dclk <= 1'b1;
      take <= 1'b1;
      clmp <= hit;
    end else begin
      cnt <= cnt_dec;
      dclk <= cnt_dec >= half;
      pulse <= 1'b0;
      take <= 1'b0;
      clmp <= 1'b0;
    end
  assign bus.div_pulse = pulse;
  assign bus.div_clk = dclk;
  assign bus.dn_take = take;
  assign bus.clamped = clmp;
endmodule
